// File: rtl/core_bus_bridge.sv
// core_bus_bridge: Wishbone-classic bridge from the core bus to the Controller
// memory port, with a local MMIO window (LED, cycle counter, status) and a
// watchdog that completes memory accesses the Controller never acknowledges.
module core_bus_bridge #(
   parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
   parameter logic [7:0]  LED_RESET      = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_cyc_i,
   input  logic        core_stb_i,
   input  logic        core_we_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_data_i,
   output logic [31:0] core_data_o,
   output logic        core_ack_o,
   output logic        mem_cyc_o,
   output logic        mem_stb_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i,
   output logic [7:0]  led_o,
   output logic        timeout_o
);

   // Watchdog counter is at least 8 bits and always wide enough to reach TIMEOUT_CYCLES.
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   // MEM_DONE is the completion cycle after the Controller ack (or watchdog
   // expiry): strobes are already down and read data is held, and the core
   // ack follows in ACK. This keeps mem_ack_i two registers away from core_ack_o.
   typedef enum logic [2:0] {
      IDLE,
      LOCAL,
      MEM_WAIT,
      MEM_DONE,
      ACK
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] to_cnt;
   logic [31:0]      cycles;
   logic             err_pend;
   logic             is_local;
   logic [31:0]      local_rdata;

   assign is_local = (core_addr_i[31:28] == MMIO_BASE[31:28]);

   // Local register read mux, word-decoded on address bits [3:2].
   always_comb begin
      local_rdata = '0;
      case (core_addr_i[3:2])
         2'd0:    local_rdata = {24'b0, led_o};
         2'd1:    local_rdata = cycles;
         2'd2:    local_rdata = {31'b0, timeout_o};
         default: local_rdata = '0;
      endcase
   end

   // Free-running cycle counter; reset forces zero, otherwise it counts and wraps.
   always_ff @(posedge clk) begin
      if (rst) cycles <= '0;
      else     cycles <= cycles + 32'd1;
   end

   // Bridge FSM: all bus outputs, LED and timeout flag are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         core_ack_o  <= 1'b0;
         core_data_o <= '0;
         mem_cyc_o   <= 1'b0;
         mem_stb_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_data_o  <= '0;
         led_o       <= LED_RESET;
         timeout_o   <= 1'b0;
         to_cnt      <= '0;
         err_pend    <= 1'b0;
      end else begin
         core_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (core_cyc_i && core_stb_i) begin
                  if (is_local) begin
                     state <= LOCAL;
                  end else begin
                     mem_cyc_o  <= 1'b1;
                     mem_stb_o  <= 1'b1;
                     mem_we_o   <= core_we_i;
                     mem_addr_o <= core_addr_i;
                     mem_data_o <= core_data_i;
                     to_cnt     <= '0;
                     state      <= MEM_WAIT;
                  end
               end
            end
            LOCAL: begin
               core_data_o <= local_rdata;
               core_ack_o  <= 1'b1;
               if (core_we_i) begin
                  case (core_addr_i[3:2])
                     2'd0:    led_o <= core_data_i[7:0];
                     2'd2:    if (core_data_i[0]) timeout_o <= 1'b0;
                     default: ;
                  endcase
               end
               state <= ACK;
            end
            MEM_WAIT: begin
               if (!core_cyc_i) begin
                  // Core abandoned the cycle: no ack, any late mem ack is ignored in IDLE.
                  mem_cyc_o <= 1'b0;
                  mem_stb_o <= 1'b0;
                  state     <= IDLE;
               end else if (mem_ack_i) begin
                  core_data_o <= mem_data_i;
                  mem_cyc_o   <= 1'b0;
                  mem_stb_o   <= 1'b0;
                  err_pend    <= 1'b0;
                  state       <= MEM_DONE;
               end else if (to_cnt == CNT_MAX) begin
                  core_data_o <= ERR_DATA;
                  mem_cyc_o   <= 1'b0;
                  mem_stb_o   <= 1'b0;
                  err_pend    <= 1'b1;
                  state       <= MEM_DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            MEM_DONE: begin
               // Flag is raised together with the ack of the failing access.
               core_ack_o <= 1'b1;
               if (err_pend) timeout_o <= 1'b1;
               state <= ACK;
            end
            ACK: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_bus_bridge.sv
// tb_core_bus_bridge: randomized and directed checks of core_bus_bridge against
// a latency/data model derived from the bridge's access rules.
module tb_core_bus_bridge;

   localparam int          T    = 8;
   localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
   localparam logic [7:0]  LEDR = 8'h3C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_cyc_i = 1'b0, core_stb_i = 1'b0, core_we_i = 1'b0;
   logic [31:0] core_addr_i = '0, core_data_i = '0;
   logic [31:0] core_data_o;
   logic        core_ack_o;
   logic        mem_cyc_o, mem_stb_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_data_o;
   logic [31:0] mem_data_i = '0;
   logic        mem_ack_i = 1'b0;
   logic [7:0]  led_o;
   logic        timeout_o;

   core_bus_bridge #(
      .MMIO_BASE(32'h8000_0000), .TIMEOUT_CYCLES(T), .ERR_DATA(ERR), .LED_RESET(LEDR)
   ) dut (
      .clk(clk), .rst(rst),
      .core_cyc_i(core_cyc_i), .core_stb_i(core_stb_i), .core_we_i(core_we_i),
      .core_addr_i(core_addr_i), .core_data_i(core_data_i),
      .core_data_o(core_data_o), .core_ack_o(core_ack_o),
      .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .led_o(led_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   // Absolute edge count, used to predict CYCLES reads.
   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   int vectors = 0;
   int miscompares = 0;

   // Reference state
   logic [7:0] led_m = LEDR;
   logic       to_m = 1'b0;
   int         rst_edge = 0;

   // Results of the last transaction
   logic [31:0] r_data;
   logic [7:0]  r_led;
   logic        r_to;
   int          r_ack, r_stb, r_e0;

   // One core access. d = cycles after mem_stb_o rises before the Controller acks
   // (d > T means it never acks). Step s = s-th cycle after the request was driven.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int d, input logic [31:0] mdat);
      logic got, loc;
      loc = (addr[31:28] == 4'h8);
      got = 1'b0; r_stb = 0; r_ack = -1; r_data = '0; r_led = '0; r_to = 1'b0;
      r_e0 = edges;
      core_cyc_i = 1'b1; core_stb_i = 1'b1; core_we_i = we;
      core_addr_i = addr; core_data_i = wdata;
      mem_data_i = ~mdat;
      for (int s = 1; s <= 600 && !got; s++) begin
         @(posedge clk); #1;
         mem_ack_i = 1'b0;
         mem_data_i = ~mdat;
         if (s == 1) begin
            vectors++;
            if (mem_stb_o !== !loc) begin
               miscompares++;
               $display("FAIL mem_stb_start: got %b want %b (addr %h)", mem_stb_o, !loc, addr);
            end
            if (!loc) begin
               vectors++;
               if (mem_addr_o !== addr || mem_we_o !== we || mem_cyc_o !== 1'b1 || (we && mem_data_o !== wdata)) begin
                  miscompares++;
                  $display("FAIL mem_request: got addr %h we %b data %h cyc %b want addr %h we %b data %h cyc 1",
                           mem_addr_o, mem_we_o, mem_data_o, mem_cyc_o, addr, we, wdata);
               end
            end
         end
         if (mem_stb_o === 1'b1) begin
            r_stb++;
            if (r_stb == d + 1) begin
               mem_ack_i = 1'b1;
               mem_data_i = mdat;
            end
         end
         if (core_ack_o === 1'b1) begin
            got = 1'b1; r_ack = s; r_data = core_data_o; r_led = led_o; r_to = timeout_o;
            core_cyc_i = 1'b0; core_stb_i = 1'b0; core_we_i = 1'b0;
         end
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL txn_ack: got no ack within 600 cycles want ack (addr %h)", addr);
         core_cyc_i = 1'b0; core_stb_i = 1'b0; core_we_i = 1'b0;
      end
      @(posedge clk); #1;
      vectors++;
      if (core_ack_o !== 1'b0) begin
         miscompares++;
         $display("FAIL ack_width: got ack %b after ack cycle want 0", core_ack_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; rst_edge = edges; led_m = LEDR; to_m = 1'b0;
      vectors++;
      if ({core_ack_o, mem_cyc_o, mem_stb_o, mem_we_o, timeout_o} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 00000", {core_ack_o, mem_cyc_o, mem_stb_o, mem_we_o, timeout_o});
      end
      vectors++;
      if (core_data_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_data_o !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %h want 0 0 0", core_data_o, mem_addr_o, mem_data_o);
      end
      vectors++;
      if (led_o !== LEDR) begin
         miscompares++;
         $display("FAIL reset_led: got %h want %h", led_o, LEDR);
      end
   endtask

   task automatic test_led();
      txn(1'b1, 32'h8000_0000, 32'h0000_00A5, 0, 32'h0);
      led_m = 8'hA5;
      vectors++;
      if (r_ack != 2 || r_led !== 8'hA5) begin
         miscompares++;
         $display("FAIL led_write: got ack_step %0d led %h want 2 a5", r_ack, r_led);
      end
      txn(1'b0, 32'h8000_0000, 32'h0, 0, 32'h0);
      vectors++;
      if (r_ack != 2 || r_data !== 32'h0000_00A5) begin
         miscompares++;
         $display("FAIL led_read: got ack_step %0d data %h want 2 000000a5", r_ack, r_data);
      end
   endtask

   task automatic test_mem_read();
      txn(1'b0, 32'h0000_0100, 32'h0, 3, 32'h1234_5678);
      vectors++;
      if (r_data !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL mem_read_data: got %h want 12345678", r_data);
      end
      vectors++;
      if (r_stb != 4 || r_ack != 6) begin
         miscompares++;
         $display("FAIL mem_read_timing: got stb %0d ack_step %0d want 4 6", r_stb, r_ack);
      end
   endtask

   task automatic test_timeout();
      txn(1'b0, 32'h0000_0200, 32'h0, 1000, 32'h0BAD_0BAD);
      to_m = 1'b1;
      vectors++;
      if (r_data !== ERR || r_to !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_resp: got data %h flag %b want %h 1", r_data, r_to, ERR);
      end
      vectors++;
      if (r_stb != T + 1 || r_ack != T + 3) begin
         miscompares++;
         $display("FAIL timeout_timing: got stb %0d ack_step %0d want %0d %0d", r_stb, r_ack, T + 1, T + 3);
      end
      txn(1'b0, 32'h8000_0008, 32'h0, 0, 32'h0);
      vectors++;
      if (r_data !== 32'h1) begin
         miscompares++;
         $display("FAIL status_read: got %h want 00000001", r_data);
      end
      txn(1'b1, 32'h8000_0008, 32'hFFFF_FFFE, 0, 32'h0);
      vectors++;
      if (r_to !== 1'b1) begin
         miscompares++;
         $display("FAIL status_write0: got flag %b want 1", r_to);
      end
      txn(1'b1, 32'h8000_0008, 32'h0000_0001, 0, 32'h0);
      to_m = 1'b0;
      vectors++;
      if (r_to !== 1'b0 || timeout_o !== 1'b0) begin
         miscompares++;
         $display("FAIL status_clear: got flag %b/%b want 0", r_to, timeout_o);
      end
   endtask

   task automatic test_cycles();
      logic [31:0] a;
      int          ea;
      txn(1'b0, 32'h8000_0004, 32'h0, 0, 32'h0);
      a = r_data; ea = r_e0;
      vectors++;
      if (a !== 32'(ea + 1 - rst_edge)) begin
         miscompares++;
         $display("FAIL cycles_abs: got %0d want %0d", a, ea + 1 - rst_edge);
      end
      repeat (7) begin @(posedge clk); #1; end
      txn(1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 0, 32'h0);
      txn(1'b0, 32'h8000_0004, 32'h0, 0, 32'h0);
      vectors++;
      if (r_data - a !== 32'(r_e0 - ea)) begin
         miscompares++;
         $display("FAIL cycles_delta: got %0d want %0d", r_data - a, r_e0 - ea);
      end
   endtask

   task automatic test_abort();
      int seen;
      seen = 0;
      core_cyc_i = 1'b1; core_stb_i = 1'b1; core_we_i = 1'b0;
      core_addr_i = 32'h0000_0300; core_data_i = '0;
      repeat (3) begin @(posedge clk); #1; end
      vectors++;
      if (mem_stb_o !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_pre: got stb %b want 1", mem_stb_o);
      end
      core_cyc_i = 1'b0; core_stb_i = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (mem_stb_o !== 1'b0 || mem_cyc_o !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_drop: got cyc %b stb %b want 0 0", mem_cyc_o, mem_stb_o);
      end
      mem_ack_i = 1'b1; mem_data_i = 32'h5555_AAAA;
      repeat (4) begin
         @(posedge clk); #1;
         mem_ack_i = 1'b0;
         if (core_ack_o !== 1'b0) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL abort_noack: got %0d ack cycles want 0", seen);
      end
      txn(1'b0, 32'h0000_0304, 32'h0, 1, 32'hC0DE_0001);
      vectors++;
      if (r_data !== 32'hC0DE_0001 || r_ack != 4) begin
         miscompares++;
         $display("FAIL abort_next: got data %h ack_step %0d want c0de0001 4", r_data, r_ack);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      txn(1'b1, 32'h8000_0000, 32'h0000_005A, 0, 32'h0);
      txn(1'b0, 32'h0000_0500, 32'h0, 1000, 32'h0);
      core_cyc_i = 1'b1; core_stb_i = 1'b1; core_we_i = 1'b1;
      core_addr_i = 32'h0000_0400; core_data_i = 32'hFACE_FACE;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; rst_edge = edges; led_m = LEDR; to_m = 1'b0;
      core_cyc_i = 1'b0; core_stb_i = 1'b0; core_we_i = 1'b0;
      vectors++;
      if ({core_ack_o, mem_cyc_o, mem_stb_o, mem_we_o, timeout_o} !== 5'b0 ||
          core_data_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_data_o !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: got ctl %b data %h addr %h wdata %h want all 0",
                  {core_ack_o, mem_cyc_o, mem_stb_o, mem_we_o, timeout_o}, core_data_o, mem_addr_o, mem_data_o);
      end
      vectors++;
      if (led_o !== LEDR) begin
         miscompares++;
         $display("FAIL rst_mid_led: got %h want %h", led_o, LEDR);
      end
      repeat (3) begin
         @(posedge clk); #1;
         if (core_ack_o !== 1'b0) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL rst_mid_noack: got %0d ack cycles want 0", seen);
      end
      txn(1'b0, 32'h8000_0004, 32'h0, 0, 32'h0);
      vectors++;
      if (r_data !== 32'(r_e0 + 1 - rst_edge)) begin
         miscompares++;
         $display("FAIL rst_mid_cycles: got %0d want %0d", r_data, r_e0 + 1 - rst_edge);
      end
      txn(1'b0, 32'h0000_0404, 32'h0, 0, 32'h7777_1234);
      vectors++;
      if (r_data !== 32'h7777_1234 || r_ack != 3) begin
         miscompares++;
         $display("FAIL rst_mid_next: got data %h ack_step %0d want 77771234 3", r_data, r_ack);
      end
   endtask

   // Back-to-back mix of random local and memory accesses against the model.
   task automatic test_random();
      logic        we, is_loc;
      logic [1:0]  rg;
      logic [31:0] tmp, addr, wdata, mdat, exp_d;
      int          d, ea, es;
      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom_range(1, 0));
         is_loc = 1'($urandom_range(1, 0));
         tmp = $urandom; wdata = $urandom; mdat = $urandom;
         if (is_loc) begin
            rg = 2'($urandom_range(3, 0));
            addr = {4'h8, tmp[27:4], rg, 2'b00};
            txn(we, addr, wdata, 0, mdat);
            case (rg)
               2'd0:    exp_d = {24'h0, led_m};
               2'd1:    exp_d = 32'(r_e0 + 1 - rst_edge);
               2'd2:    exp_d = {31'h0, to_m};
               default: exp_d = 32'h0;
            endcase
            if (we && rg == 2'd0) led_m = wdata[7:0];
            if (we && rg == 2'd2 && wdata[0]) to_m = 1'b0;
            vectors++;
            if (r_ack != 2 || (!we && r_data !== exp_d)) begin
               miscompares++;
               $display("FAIL rnd_local[%0d]: got ack_step %0d data %h want 2 %h (reg %0d we %b)", i, r_ack, r_data, exp_d, rg, we);
            end
         end else begin
            d = $urandom_range(12, 0);
            addr = tmp & 32'h7FFF_FFFF;
            txn(we, addr, wdata, d, mdat);
            if (d <= T) begin ea = d + 3; es = d + 1; exp_d = mdat; end
            else begin ea = T + 3; es = T + 1; exp_d = ERR; to_m = 1'b1; end
            vectors++;
            if (r_ack != ea || r_stb != es || ((!we || d > T) && r_data !== exp_d)) begin
               miscompares++;
               $display("FAIL rnd_mem[%0d]: got ack_step %0d stb %0d data %h want %0d %0d %h (d %0d we %b)",
                        i, r_ack, r_stb, r_data, ea, es, exp_d, d, we);
            end
         end
         vectors++;
         if (r_led !== led_m || r_to !== to_m) begin
            miscompares++;
            $display("FAIL rnd_regs[%0d]: got led %h flag %b want %h %b", i, r_led, r_to, led_m, to_m);
         end
      end
   endtask

   initial begin
      test_reset();
      test_led();
      test_mem_read();
      test_timeout();
      test_cycles();
      test_abort();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
